// File: rtl/pwm_deadtime_pkg.sv
// Shared constants and types for the complementary PWM dead-time inserter.
package pwm_deadtime_pkg;

  localparam int unsigned DtWidthDefault = 8;

  localparam logic [7:0] AddrCtrl   = 8'h00;
  localparam logic [7:0] AddrDtRise = 8'h04;
  localparam logic [7:0] AddrDtFall = 8'h08;
  localparam logic [7:0] AddrStatus = 8'h0C;

  typedef enum logic [2:0] {
    StOff,
    StLsOn,
    StDtToHs,
    StHsOn,
    StDtToLs
  } ch_state_e;

endpackage

// File: rtl/pwm_deadtime_channel.sv
// One complementary output pair: break-before-make FSM with a dead-time countdown.
module pwm_deadtime_channel
  import pwm_deadtime_pkg::*;
#(
  parameter int unsigned DT_WIDTH = DtWidthDefault
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                active_i,
  input  logic                pwm_i,
  input  logic [DT_WIDTH-1:0] dt_rise_i,
  input  logic [DT_WIDTH-1:0] dt_fall_i,
  output logic                hs_o,
  output logic                ls_o
);

  ch_state_e           state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StOff;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!active_i) begin
      state_d = StOff;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StOff, StLsOn, StHsOn: begin
          // A zero dead time skips the DT state entirely.
          if (pwm_i && state_q != StHsOn) begin
            state_d = (dt_rise_i == '0) ? StHsOn : StDtToHs;
            cnt_d   = dt_rise_i;
          end else if (!pwm_i && state_q != StLsOn) begin
            state_d = (dt_fall_i == '0) ? StLsOn : StDtToLs;
            cnt_d   = dt_fall_i;
          end
        end
        StDtToHs: begin
          if (!pwm_i) begin
            state_d = StLsOn;
            cnt_d   = '0;
          end else if (cnt_q <= DT_WIDTH'(1)) begin
            state_d = StHsOn;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        StDtToLs: begin
          if (pwm_i) begin
            state_d = StHsOn;
            cnt_d   = '0;
          end else if (cnt_q <= DT_WIDTH'(1)) begin
            state_d = StLsOn;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        default: begin
          state_d = StOff;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Gating by active_i kills the drive in the same cycle a fault or disable arrives.
  always_comb begin
    hs_o = 1'b0;
    ls_o = 1'b0;
    if (active_i) begin
      hs_o = (state_q == StHsOn);
      ls_o = (state_q == StLsOn);
    end
  end

endmodule

// File: rtl/pwm_deadtime.sv
// Dead-time inserter: CSR block, fault latch and one channel FSM per output pair.
module pwm_deadtime
  import pwm_deadtime_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DT_WIDTH     = DtWidthDefault
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [7:0]              csr_addr_i,
  input  logic                    csr_we_i,
  input  logic [31:0]             csr_wdata_i,
  output logic [31:0]             csr_rdata_o,
  input  logic [NUM_CHANNELS-1:0] pwm_i,
  input  logic [NUM_CHANNELS-1:0] pwm_en_i,
  input  logic                    fault_i,
  output logic [NUM_CHANNELS-1:0] hs_o,
  output logic [NUM_CHANNELS-1:0] ls_o,
  output logic [NUM_CHANNELS-1:0] oe_o
);

  logic                    ctrl_en_q, ctrl_en_d;
  logic [DT_WIDTH-1:0]     dt_rise_q, dt_rise_d;
  logic [DT_WIDTH-1:0]     dt_fall_q, dt_fall_d;
  logic                    fault_q, fault_d;
  logic [NUM_CHANNELS-1:0] pwm_q;
  logic [NUM_CHANNELS-1:0] active;
  logic                    wr_ctrl;
  logic                    unused_wdata;

  assign unused_wdata = ^csr_wdata_i;
  assign wr_ctrl      = csr_we_i && (csr_addr_i == AddrCtrl);

  always_comb begin
    ctrl_en_d = wr_ctrl ? csr_wdata_i[0] : ctrl_en_q;
    dt_rise_d = (csr_we_i && csr_addr_i == AddrDtRise) ? csr_wdata_i[DT_WIDTH-1:0] : dt_rise_q;
    dt_fall_d = (csr_we_i && csr_addr_i == AddrDtFall) ? csr_wdata_i[DT_WIDTH-1:0] : dt_fall_q;
    // A live fault always wins over a clear request.
    fault_d   = fault_q;
    if (fault_i) begin
      fault_d = 1'b1;
    end else if (wr_ctrl && csr_wdata_i[1]) begin
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_en_q <= 1'b0;
      dt_rise_q <= '0;
      dt_fall_q <= '0;
      fault_q   <= 1'b0;
      pwm_q     <= '0;
    end else begin
      ctrl_en_q <= ctrl_en_d;
      dt_rise_q <= dt_rise_d;
      dt_fall_q <= dt_fall_d;
      fault_q   <= fault_d;
      pwm_q     <= pwm_i;
    end
  end

  assign active = {NUM_CHANNELS{ctrl_en_q & ~fault_q & ~fault_i}} & pwm_en_i;
  assign oe_o   = {NUM_CHANNELS{ctrl_en_q}} & pwm_en_i;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    pwm_deadtime_channel #(
      .DT_WIDTH (DT_WIDTH)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .active_i  (active[k]),
      .pwm_i     (pwm_q[k]),
      .dt_rise_i (dt_rise_q),
      .dt_fall_i (dt_fall_q),
      .hs_o      (hs_o[k]),
      .ls_o      (ls_o[k])
    );
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      AddrCtrl:   csr_rdata_o[0] = ctrl_en_q;
      AddrDtRise: csr_rdata_o[DT_WIDTH-1:0] = dt_rise_q;
      AddrDtFall: csr_rdata_o[DT_WIDTH-1:0] = dt_fall_q;
      AddrStatus: begin
        csr_rdata_o[0]                 = fault_q;
        csr_rdata_o[8 +: NUM_CHANNELS]  = hs_o;
        csr_rdata_o[16 +: NUM_CHANNELS] = ls_o;
      end
      default: ;
    endcase
  end

endmodule
